// File: rtl/time_pkg.sv
// Shared BCD limits and run encoding for the hh:mm:ss time-keeping stage.
package time_pkg;

  typedef logic [7:0] bcd_pair_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIG_MAX      = 4'd9;
  localparam bcd_pair_t  SEC_MAX      = {SEC_TENS_MAX, DIG_MAX};
  localparam bcd_pair_t  HOUR24_MAX   = 8'h23;
  localparam bcd_pair_t  HOUR12_MAX   = 8'h12;
  localparam bcd_pair_t  HOUR12_MIN   = 8'h01;
  // Last hour before the start-of-day wrap in 12h mode (11:59:59 -> 12:00:00).
  localparam bcd_pair_t  HOUR12_LAST  = 8'h11;

  localparam logic [1:0] EN_RUN = 2'b01;

  // With both nibbles at most 9, the hex ordering of a BCD pair matches its
  // decimal ordering, so plain comparisons give the range check.
  function automatic logic bcd_in_range(input bcd_pair_t v, input bcd_pair_t lo,
                                        input bcd_pair_t hi);
    return (v[7:4] <= DIG_MAX) && (v[3:0] <= DIG_MAX) && (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD field counter with wrap MAX_VAL -> MIN_VAL and validated load.
module bcd_pair_counter
  import time_pkg::*;
#(
  parameter bcd_pair_t MAX_VAL = 8'h59,
  parameter bcd_pair_t MIN_VAL = 8'h00,
  parameter bcd_pair_t RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       valid,
  output logic       carry_out,
  output logic [7:0] value
);

  bcd_pair_t next_inc;

  assign valid     = bcd_in_range(load_value, MIN_VAL, MAX_VAL);
  // Combinational carry so the whole hh:mm:ss chain resolves on one edge.
  assign carry_out = inc && (value == MAX_VAL);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    next_inc = value;
    if (value == MAX_VAL)
      next_inc = MIN_VAL;
    else if (value[3:0] == DIG_MAX)
      next_inc = {value[7:4] + 4'd1, 4'd0};
    else
      next_inc = {value[7:4], value[3:0] + 4'd1};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= RST_VAL;
    else if (load)
      value <= valid ? load_value : RST_VAL;
    else if (inc)
      value <= next_inc;
  end

endmodule

// File: rtl/time_bcd_counter.sv
// hh:mm:ss BCD time counter: 1 Hz counting, pause, hour/minute load with
// validation, and a one-clk day-rollover pulse.
module time_bcd_counter
  import time_pkg::*;
#(
  parameter int HOUR_MODE = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [1:0] en_pause,
  input  logic       set,
  input  logic [3:0] init_value_m0,
  input  logic [3:0] init_value_m1,
  input  logic [3:0] init_value_h0,
  input  logic [3:0] init_value_h1,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic       day_carry,
  output logic       load_err
);

  localparam bcd_pair_t HR_MIN = (HOUR_MODE == 12) ? HOUR12_MIN : 8'h00;
  localparam bcd_pair_t HR_MAX = (HOUR_MODE == 12) ? HOUR12_MAX : HOUR24_MAX;
  localparam bcd_pair_t HR_RST = (HOUR_MODE == 12) ? HOUR12_MAX : 8'h00;

  bcd_pair_t sec_value, min_value, hr_value;
  logic      sec_valid, min_valid, hr_valid;
  logic      sec_carry, min_carry, hr_carry;
  logic      run_tick, day_wrap, err_now, err_new;
  logic      set_q;
  logic [15:0] init_q;

  // Load wins over counting, so ticks arriving during set are discarded.
  assign run_tick = tick_1hz && (en_pause == EN_RUN) && !set;

  bcd_pair_counter #(.MAX_VAL(SEC_MAX), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_sec (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (run_tick),
    .load       (set),
    .load_value (8'h00),
    .valid      (sec_valid),
    .carry_out  (sec_carry),
    .value      (sec_value)
  );

  bcd_pair_counter #(.MAX_VAL(SEC_MAX), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_min (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (sec_carry),
    .load       (set),
    .load_value ({init_value_m1, init_value_m0}),
    .valid      (min_valid),
    .carry_out  (min_carry),
    .value      (min_value)
  );

  bcd_pair_counter #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_hr (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (min_carry),
    .load       (set),
    .load_value ({init_value_h1, init_value_h0}),
    .valid      (hr_valid),
    .carry_out  (hr_carry),
    .value      (hr_value)
  );

  // In 12h mode the hour wrap (12->01) is not the day boundary; 11->12 is.
  assign day_wrap = (HOUR_MODE == 12) ? (min_carry && (hr_value == HOUR12_LAST))
                                      : hr_carry;

  // Report an invalid load once per distinct set episode / value combination.
  assign err_now = set && !(sec_valid && min_valid && hr_valid);
  assign err_new = !set_q ||
                   (init_q != {init_value_h1, init_value_h0, init_value_m1, init_value_m0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_carry <= 1'b0;
      load_err  <= 1'b0;
      set_q     <= 1'b0;
      init_q    <= '0;
    end else begin
      day_carry <= day_wrap;
      load_err  <= err_now && err_new;
      set_q     <= set;
      init_q    <= {init_value_h1, init_value_h0, init_value_m1, init_value_m0};
    end
  end

  assign dig0 = sec_value[3:0];
  assign dig1 = sec_value[7:4];
  assign dig2 = min_value[3:0];
  assign dig3 = min_value[7:4];
  assign dig4 = hr_value[3:0];
  assign dig5 = hr_value[7:4];

endmodule

// File: tb/tb_time_bcd_counter.sv
// Directed bench for time_bcd_counter: a 24h and a 12h instance share stimulus.
module tb_time_bcd_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [1:0] en_pause = 2'b00;
  logic       set = 1'b0;
  logic [3:0] m0 = '0, m1 = '0, h0 = '0, h1 = '0;

  logic [3:0] a0, a1, a2, a3, a4, a5;
  logic [3:0] b0, b1, b2, b3, b4, b5;
  logic       dc24, dc12, le24, le12;
  logic       dc24_seen, dc12_seen;

  int n_checks = 0;
  int n_errors = 0;

  time_bcd_counter #(.HOUR_MODE(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .en_pause(en_pause), .set(set),
    .init_value_m0(m0), .init_value_m1(m1), .init_value_h0(h0), .init_value_h1(h1),
    .dig0(a0), .dig1(a1), .dig2(a2), .dig3(a3), .dig4(a4), .dig5(a5),
    .day_carry(dc24), .load_err(le24)
  );

  time_bcd_counter #(.HOUR_MODE(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .en_pause(en_pause), .set(set),
    .init_value_m0(m0), .init_value_m1(m1), .init_value_h0(h0), .init_value_h1(h1),
    .dig0(b0), .dig1(b1), .dig2(b2), .dig3(b3), .dig4(b4), .dig5(b5),
    .day_carry(dc12), .load_err(le12)
  );

  always #5 clk = ~clk;

  wire [23:0] t24 = {a5, a4, a3, a2, a1, a0};
  wire [23:0] t12 = {b5, b4, b3, b2, b1, b0};

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    dc24_seen = dc24_seen | dc24;
    dc12_seen = dc12_seen | dc12;
  endtask

  task automatic ticks(input int n);
    tick_1hz = 1'b1;
    repeat (n) step();
    tick_1hz = 1'b0;
  endtask

  task automatic load(input logic [3:0] vh1, vh0, vm1, vm0);
    h1 = vh1; h0 = vh0; m1 = vm1; m0 = vm0;
    set = 1'b1;
    step();
    set = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dc24_seen = 1'b0;
    dc12_seen = 1'b0;

    // Reset values
    step(); step();
    check("rst_t24", t24, 24'h000000);
    check("rst_t12", t12, 24'h120000);
    check("rst_dc", {dc24, dc12}, 0);
    check("rst_le", {le24, le12}, 0);

    // Count to 12:34:56, then asynchronous reset between edges
    rst_n = 1'b1;
    load(4'd1, 4'd2, 4'd3, 4'd4);
    en_pause = 2'b01;
    ticks(56);
    check("pre_rst_t24", t24, 24'h123456);
    check("pre_rst_t12", t12, 24'h123456);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_t24", t24, 24'h000000);
    check("async_rst_t12", t12, 24'h120000);
    check("async_rst_dc", {dc24, dc12}, 0);
    #1 rst_n = 1'b1;

    // Load 23:59, count through the day wrap
    load(4'd2, 4'd3, 4'd5, 4'd9);
    check("load2359_t24", t24, 24'h235900);
    check("load2359_le24", le24, 0);
    check("load2359_t12", t12, 24'h125900);
    check("load2359_le12", le12, 1);
    ticks(1);
    check("first_tick", t24, 24'h235901);
    dc24_seen = 1'b0;
    ticks(58);
    check("t235959", t24, 24'h235959);
    check("no_early_dc", dc24_seen, 0);
    ticks(1);
    check("wrap_t24", t24, 24'h000000);
    check("wrap_dc24", dc24, 1);
    step();
    check("dc24_one_clk", dc24, 0);
    check("after_wrap_hold", t24, 24'h000000);

    // Full carry chain 09:59:59 -> 10:00:00
    load(4'd0, 4'd9, 4'd5, 4'd9);
    ticks(59);
    check("t095959", t24, 24'h095959);
    ticks(1);
    check("chain_t24", t24, 24'h100000);
    check("chain_no_dc", dc24, 0);

    // Pause drops ticks for every non-run encoding
    en_pause = 2'b10;
    ticks(5);
    check("pause10", t24, 24'h100000);
    en_pause = 2'b11;
    ticks(2);
    check("pause11", t24, 24'h100000);
    en_pause = 2'b00;
    ticks(2);
    check("pause00", t24, 24'h100000);
    en_pause = 2'b01;
    ticks(1);
    check("resume", t24, 24'h100001);

    // Invalid load with ticks during set
    h1 = 4'd2; h0 = 4'd7; m1 = 4'd6; m0 = 4'd0;
    set = 1'b1;
    tick_1hz = 1'b1;
    step();
    check("inv_load_t24", t24, 24'h000000);
    check("inv_load_le", le24, 1);
    step();
    check("inv_hold_le", le24, 0);
    check("inv_tick_ignored", t24, 24'h000000);
    m1 = 4'd1; m0 = 4'd5;
    step();
    check("inv_change_t24", t24, 24'h001500);
    check("inv_change_le", le24, 1);
    set = 1'b0;
    tick_1hz = 1'b0;
    step();
    check("inv_release_le", le24, 0);
    set = 1'b1;
    step();
    check("inv_reassert_le", le24, 1);
    set = 1'b0;
    step();

    // 12h mode: 12:59:59 -> 01:00:00 without day_carry
    load(4'd1, 4'd2, 4'd5, 4'd9);
    check("load1259_t12", t12, 24'h125900);
    check("load1259_le12", le12, 0);
    dc12_seen = 1'b0;
    ticks(60);
    check("h12_wrap_t12", t12, 24'h010000);
    check("h12_wrap_no_dc", dc12_seen, 0);
    check("h24_13", t24, 24'h130000);

    // 12h mode: 11:59:59 -> 12:00:00 is the day boundary
    load(4'd1, 4'd1, 4'd5, 4'd9);
    ticks(59);
    check("t115959", t12, 24'h115959);
    ticks(1);
    check("day12_t12", t12, 24'h120000);
    check("day12_dc12", dc12, 1);
    check("day12_no_dc24", dc24, 0);
    step();
    check("dc12_one_clk", dc12, 0);

    // 12h mode rejects hour 00, 24h accepts it
    load(4'd0, 4'd0, 4'd3, 4'd0);
    check("h00_t12", t12, 24'h123000);
    check("h00_le12", le12, 1);
    check("h00_t24", t24, 24'h003000);
    check("h00_le24", le24, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
